// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the single-port memory arbiter (mem_port_arbiter).
// Build option: define MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration on contention.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_RESP   = 2'd2
    } arb_state_e;

    typedef enum logic {
        ARB_OWN_I = 1'b0,
        ARB_OWN_D = 1'b1
    } arb_owner_e;

    localparam int MEM_LATENCY = 2;
    // Latency counter width covers the legal LATENCY range 1..15.
    localparam int CNT_W = 4;

endpackage

// File: rtl/mem_arb_pick.sv
// Two-way requester selector for mem_port_arbiter.
// Build option: MEM_ARB_ROUND_ROBIN_EN selects round-robin, otherwise fixed D-over-I priority.
module mem_arb_pick
    import mem_port_arbiter_pkg::*;
(
    input  logic       i_req,
    input  logic       d_req,
`ifdef MEM_ARB_ROUND_ROBIN_EN
    input  arb_owner_e last_owner,
`endif
    output logic       sel_i,
    output logic       sel_d
);

    // Pick at most one requester per cycle.
    always_comb begin
        sel_i = 1'b0;
        sel_d = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        if (i_req && d_req) begin
            // On contention favour whoever was not served last.
            if (last_owner == ARB_OWN_I) begin
                sel_d = 1'b1;
            end else begin
                sel_i = 1'b1;
            end
        end else begin
            sel_i = i_req;
            sel_d = d_req;
        end
`else
        sel_d = d_req;
        sel_i = i_req & ~d_req;
`endif
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the fetch (I) and load/store (D) ports onto one single-port memory, one access at a time.
// Build option: MEM_ARB_ROUND_ROBIN_EN enables round-robin arbitration (default: fixed D-over-I).
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int LATENCY = MEM_LATENCY,
    parameter int AW      = 32,
    parameter int DW      = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_gnt,
    output logic          i_rvalid,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LATENCY - 1);

    arb_state_e       state_r;
    arb_state_e       state_n_s;
    arb_owner_e       owner_r;
    logic [CNT_W-1:0] cnt_r;
    logic [AW-1:0]    addr_r;
    logic             we_r;
    logic [DW-1:0]    wdata_r;
    logic [DW-1:0]    rdata_r;
    logic             sel_i_s;
    logic             sel_d_s;
    logic             i_gnt_s;
    logic             d_gnt_s;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    arb_owner_e       last_owner_r;

    // Round-robin pointer: remembers the most recently granted requester.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_owner_r <= ARB_OWN_I;
        end else if (d_gnt_s) begin
            last_owner_r <= ARB_OWN_D;
        end else if (i_gnt_s) begin
            last_owner_r <= ARB_OWN_I;
        end
    end
`endif

    mem_arb_pick u_pick (
        .i_req      (i_req),
        .d_req      (d_req),
`ifdef MEM_ARB_ROUND_ROBIN_EN
        .last_owner (last_owner_r),
`endif
        .sel_i      (sel_i_s),
        .sel_d      (sel_d_s)
    );

    assign i_gnt_s = (state_r == ARB_IDLE) & i_req & sel_i_s;
    assign d_gnt_s = (state_r == ARB_IDLE) & d_req & sel_d_s;

    // Next-state logic for the IDLE -> ACCESS -> RESP cycle.
    always_comb begin
        state_n_s = state_r;
        case (state_r)
            ARB_IDLE: begin
                if (i_gnt_s || d_gnt_s) begin
                    state_n_s = ARB_ACCESS;
                end else begin
                    state_n_s = ARB_IDLE;
                end
            end
            ARB_ACCESS: begin
                if (cnt_r == LAST_CNT) begin
                    state_n_s = ARB_RESP;
                end else begin
                    state_n_s = ARB_ACCESS;
                end
            end
            ARB_RESP: state_n_s = ARB_IDLE;
            default:  state_n_s = ARB_IDLE;
        endcase
    end

    // State register, request latches, latency counter and read-data capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ARB_IDLE;
            owner_r <= ARB_OWN_I;
            cnt_r   <= '0;
            addr_r  <= '0;
            we_r    <= 1'b0;
            wdata_r <= '0;
            rdata_r <= '0;
        end else begin
            state_r <= state_n_s;
            case (state_r)
                ARB_IDLE: begin
                    if (d_gnt_s) begin
                        owner_r <= ARB_OWN_D;
                        addr_r  <= d_addr;
                        we_r    <= d_we;
                        wdata_r <= d_wdata;
                        cnt_r   <= '0;
                    end else if (i_gnt_s) begin
                        owner_r <= ARB_OWN_I;
                        addr_r  <= i_addr;
                        we_r    <= 1'b0;
                        wdata_r <= '0;
                        cnt_r   <= '0;
                    end
                end
                ARB_ACCESS: begin
                    cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (cnt_r == LAST_CNT) begin
                        // Stores report zero data so the D port never sees stale load data.
                        rdata_r <= we_r ? '0 : mem_rdata;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign i_gnt     = i_gnt_s;
    assign d_gnt     = d_gnt_s;
    assign mem_en    = (state_r == ARB_ACCESS);
    assign mem_we    = (state_r == ARB_ACCESS) & we_r;
    assign mem_addr  = addr_r;
    assign mem_wdata = wdata_r;
    assign i_rvalid  = (state_r == ARB_RESP) & (owner_r == ARB_OWN_I);
    assign d_rvalid  = (state_r == ARB_RESP) & (owner_r == ARB_OWN_D);
    assign i_rdata   = rdata_r;
    assign d_rdata   = rdata_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (LATENCY=2 main instance, LATENCY=1 back-to-back instance).
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        i_req, d_req, d_we;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic        i_gnt, i_rvalid, d_gnt, d_rvalid;
    logic [31:0] i_rdata, d_rdata;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic        b_i_req;
    logic [31:0] b_i_addr;
    logic        b_i_gnt, b_i_rvalid, b_d_gnt, b_d_rvalid;
    logic [31:0] b_i_rdata, b_d_rdata;
    logic        b_mem_en, b_mem_we;
    logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;
    logic        b_d_req, b_d_we;
    logic [31:0] b_d_addr, b_d_wdata;

    int checks = 0;
    int errors = 0;

    // Memory model: address 4 holds an addi instruction, everything else is addr ^ 0xA5A5_0000.
    assign mem_rdata   = (mem_addr == 32'h4) ? 32'h0010_0093 : (mem_addr ^ 32'hA5A5_0000);
    assign b_mem_rdata = b_mem_addr ^ 32'hA5A5_0000;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter #(.LATENCY(2), .AW(32), .DW(32)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    mem_port_arbiter #(.LATENCY(1), .AW(32), .DW(32)) dut1 (
        .clk(clk), .rst(rst),
        .i_req(b_i_req), .i_addr(b_i_addr), .i_gnt(b_i_gnt), .i_rvalid(b_i_rvalid), .i_rdata(b_i_rdata),
        .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
        .d_gnt(b_d_gnt), .d_rvalid(b_d_rvalid), .d_rdata(b_d_rdata),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_rdata(b_mem_rdata)
    );

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        i_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0;
        b_i_req = 1'b0; b_i_addr = 32'h0;
        b_d_req = 1'b0; b_d_we = 1'b0; b_d_addr = 32'h0; b_d_wdata = 32'h0;
        nxt();
        nxt();
        @(negedge clk);
        checks++;
        if ({mem_en, mem_we, i_rvalid, d_rvalid, i_gnt, d_gnt} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected %b", {mem_en, mem_we, i_rvalid, d_rvalid, i_gnt, d_gnt}, 6'b0);
        end
        checks++;
        if ({mem_addr, mem_wdata, i_rdata, d_rdata} !== 128'h0) begin
            errors++;
            $display("FAIL reset_data: got %h expected %h", {mem_addr, mem_wdata, i_rdata, d_rdata}, 128'h0);
        end
        checks++;
        if ({b_mem_en, b_i_rvalid, b_mem_addr} !== 34'h0) begin
            errors++;
            $display("FAIL reset_lat1: got %h expected %h", {b_mem_en, b_i_rvalid, b_mem_addr}, 34'h0);
        end
        nxt();
        rst = 1'b0;
    endtask

    task automatic test_fetch();
        nxt();
        i_req = 1'b1; i_addr = 32'h0000_0004;
        @(negedge clk);
        checks++;
        if ({i_gnt, d_gnt} !== 2'b10) begin
            errors++;
            $display("FAIL fetch_gnt: got %b expected %b", {i_gnt, d_gnt}, 2'b10);
        end
        for (int c = 1; c <= 2; c++) begin
            nxt();
            i_req = 1'b0;
            @(negedge clk);
            checks++;
            if ({mem_en, mem_we, mem_addr, i_rvalid, d_rvalid} !== {1'b1, 1'b0, 32'h4, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL fetch_access%0d: got en=%b we=%b addr=%h irv=%b drv=%b expected en=1 we=0 addr=00000004 irv=0 drv=0",
                         c, mem_en, mem_we, mem_addr, i_rvalid, d_rvalid);
            end
        end
        nxt();
        @(negedge clk);
        checks++;
        if ({i_rvalid, d_rvalid, mem_en, i_rdata} !== {1'b1, 1'b0, 1'b0, 32'h0010_0093}) begin
            errors++;
            $display("FAIL fetch_resp: got irv=%b drv=%b en=%b rdata=%h expected irv=1 drv=0 en=0 rdata=00100093",
                     i_rvalid, d_rvalid, mem_en, i_rdata);
        end
    endtask

    task automatic test_store();
        nxt();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        checks++;
        if ({i_gnt, d_gnt} !== 2'b01) begin
            errors++;
            $display("FAIL store_gnt: got %b expected %b", {i_gnt, d_gnt}, 2'b01);
        end
        for (int c = 1; c <= 2; c++) begin
            nxt();
            d_req = 1'b0; d_we = 1'b0; d_wdata = 32'h0;
            @(negedge clk);
            checks++;
            if ({mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF}) begin
                errors++;
                $display("FAIL store_access%0d: got en=%b we=%b addr=%h wdata=%h expected en=1 we=1 addr=00000100 wdata=deadbeef",
                         c, mem_en, mem_we, mem_addr, mem_wdata);
            end
        end
        nxt();
        @(negedge clk);
        checks++;
        if ({d_rvalid, i_rvalid, mem_we, d_rdata} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL store_resp: got drv=%b irv=%b we=%b rdata=%h expected drv=1 irv=0 we=0 rdata=00000000",
                     d_rvalid, i_rvalid, mem_we, d_rdata);
        end
    endtask

    task automatic test_contention();
        logic [1:0] exp_gnt;
        // Phase 1: D wins, then the waiting I request is served as a lone requester.
        nxt();
        i_req = 1'b1; i_addr = 32'h8;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
        @(negedge clk);
        checks++;
        if ({i_gnt, d_gnt} !== 2'b01) begin
            errors++;
            $display("FAIL cont_first: got %b expected %b", {i_gnt, d_gnt}, 2'b01);
        end
        nxt();
        d_req = 1'b0;
        nxt();
        nxt();
        @(negedge clk);
        checks++;
        if ({i_gnt, d_gnt, d_rvalid, d_rdata} !== {2'b00, 1'b1, 32'hA5A5_0200}) begin
            errors++;
            $display("FAIL cont_d_resp: got gnt=%b drv=%b rdata=%h expected gnt=00 drv=1 rdata=a5a50200",
                     {i_gnt, d_gnt}, d_rvalid, d_rdata);
        end
        nxt();
        @(negedge clk);
        checks++;
        if ({i_gnt, d_gnt} !== 2'b10) begin
            errors++;
            $display("FAIL cont_second: got %b expected %b", {i_gnt, d_gnt}, 2'b10);
        end
        nxt();
        i_req = 1'b0;
        nxt();
        nxt();
        @(negedge clk);
        checks++;
        if ({i_rvalid, d_rvalid, i_rdata} !== {1'b1, 1'b0, 32'hA5A5_0008}) begin
            errors++;
            $display("FAIL cont_i_resp: got irv=%b drv=%b rdata=%h expected irv=1 drv=0 rdata=a5a50008",
                     i_rvalid, d_rvalid, i_rdata);
        end
        // Phase 2: both held across two arbitration rounds.
        nxt();
        i_req = 1'b1; i_addr = 32'hC0;
        d_req = 1'b1; d_addr = 32'h2C0;
        @(negedge clk);
        checks++;
        if ({i_gnt, d_gnt} !== 2'b01) begin
            errors++;
            $display("FAIL cont_third: got %b expected %b", {i_gnt, d_gnt}, 2'b01);
        end
        nxt();
        nxt();
        nxt();
        nxt();
`ifdef MEM_ARB_ROUND_ROBIN_EN
        exp_gnt = 2'b10;
`else
        exp_gnt = 2'b01;
`endif
        @(negedge clk);
        checks++;
        if ({i_gnt, d_gnt} !== exp_gnt) begin
            errors++;
            $display("FAIL cont_fourth: got %b expected %b", {i_gnt, d_gnt}, exp_gnt);
        end
        nxt();
        i_req = 1'b0; d_req = 1'b0;
        nxt();
        nxt();
        @(negedge clk);
        checks++;
        if ({i_rvalid, d_rvalid} !== exp_gnt) begin
            errors++;
            $display("FAIL cont_fourth_resp: got %b expected %b", {i_rvalid, d_rvalid}, exp_gnt);
        end
    endtask

    task automatic test_reset_mid();
        nxt();
        i_req = 1'b1; i_addr = 32'hC;
        @(negedge clk);
        checks++;
        if (i_gnt !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_gnt: got %b expected %b", i_gnt, 1'b1);
        end
        nxt();
        i_req = 1'b0; rst = 1'b1;
        @(negedge clk);
        checks++;
        if (mem_en !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_access: got %b expected %b", mem_en, 1'b1);
        end
        nxt();
        rst = 1'b0;
        i_req = 1'b1; i_addr = 32'h10;
        @(negedge clk);
        checks++;
        if ({mem_en, i_rvalid, i_gnt} !== 3'b001) begin
            errors++;
            $display("FAIL rstmid_after: got en/irv/gnt=%b expected %b", {mem_en, i_rvalid, i_gnt}, 3'b001);
        end
        for (int c = 1; c <= 2; c++) begin
            nxt();
            i_req = 1'b0;
            @(negedge clk);
            checks++;
            if ({i_rvalid, d_rvalid, mem_addr} !== {2'b00, 32'h10}) begin
                errors++;
                $display("FAIL rstmid_norv%0d: got rv=%b addr=%h expected rv=00 addr=00000010",
                         c, {i_rvalid, d_rvalid}, mem_addr);
            end
        end
        nxt();
        @(negedge clk);
        checks++;
        if ({i_rvalid, i_rdata} !== {1'b1, 32'hA5A5_0010}) begin
            errors++;
            $display("FAIL rstmid_resp: got irv=%b rdata=%h expected irv=1 rdata=a5a50010", i_rvalid, i_rdata);
        end
    endtask

    task automatic test_withdraw();
        nxt();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
        @(negedge clk);
        checks++;
        if (d_gnt !== 1'b1) begin
            errors++;
            $display("FAIL wd_dgnt: got %b expected %b", d_gnt, 1'b1);
        end
        nxt();
        d_req = 1'b0;
        i_req = 1'b1; i_addr = 32'h40;
        @(negedge clk);
        checks++;
        if ({i_gnt, mem_addr} !== {1'b0, 32'h300}) begin
            errors++;
            $display("FAIL wd_access1: got gnt=%b addr=%h expected gnt=0 addr=00000300", i_gnt, mem_addr);
        end
        nxt();
        i_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({i_gnt, mem_en, mem_addr} !== {1'b0, 1'b1, 32'h300}) begin
            errors++;
            $display("FAIL wd_access2: got gnt=%b en=%b addr=%h expected gnt=0 en=1 addr=00000300", i_gnt, mem_en, mem_addr);
        end
        nxt();
        @(negedge clk);
        checks++;
        if ({d_rvalid, i_rvalid, d_rdata} !== {2'b10, 32'hA5A5_0300}) begin
            errors++;
            $display("FAIL wd_resp: got drv=%b irv=%b rdata=%h expected drv=1 irv=0 rdata=a5a50300", d_rvalid, i_rvalid, d_rdata);
        end
        for (int c = 1; c <= 2; c++) begin
            nxt();
            @(negedge clk);
            checks++;
            if ({i_gnt, mem_en, i_rvalid} !== 3'b000) begin
                errors++;
                $display("FAIL wd_idle%0d: got gnt/en/irv=%b expected %b", c, {i_gnt, mem_en, i_rvalid}, 3'b000);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] addr;
        nxt();
        b_i_req = 1'b1;
        addr = 32'h20;
        b_i_addr = addr;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if ({b_i_gnt, b_mem_en} !== 2'b10) begin
                errors++;
                $display("FAIL b2b_gnt%0d: got gnt/en=%b expected %b", k, {b_i_gnt, b_mem_en}, 2'b10);
            end
            nxt();
            b_i_addr = addr + 32'h4;
            @(negedge clk);
            checks++;
            if ({b_i_gnt, b_mem_en, b_i_rvalid, b_mem_addr} !== {3'b010, addr}) begin
                errors++;
                $display("FAIL b2b_access%0d: got gnt=%b en=%b irv=%b addr=%h expected gnt=0 en=1 irv=0 addr=%h",
                         k, b_i_gnt, b_mem_en, b_i_rvalid, b_mem_addr, addr);
            end
            nxt();
            @(negedge clk);
            checks++;
            if ({b_i_gnt, b_mem_en, b_i_rvalid, b_i_rdata} !== {3'b001, addr ^ 32'hA5A5_0000}) begin
                errors++;
                $display("FAIL b2b_resp%0d: got gnt=%b en=%b irv=%b rdata=%h expected gnt=0 en=0 irv=1 rdata=%h",
                         k, b_i_gnt, b_mem_en, b_i_rvalid, b_i_rdata, addr ^ 32'hA5A5_0000);
            end
            nxt();
            addr = addr + 32'h4;
        end
        b_i_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_store();
        test_contention();
        test_reset_mid();
        test_withdraw();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
